// File: rtl/tb_mem_pkg.sv
// Shared types and helpers for the multi-port simulation memory.
// Holds the response-pipeline control record and the port-index width helper.
package tb_mem_pkg;

  // Widest port index a response entry can carry (up to 256 ports).
  localparam int unsigned MaxPortW = 8;

  typedef logic [MaxPortW-1:0] port_id_t;

  // Control half of a response pipeline entry; the data half is sized by the top.
  typedef struct packed {
    logic     valid;
    port_id_t port;
  } resp_ctrl_t;

  // Bits needed to index n ports; never less than one so vectors stay legal.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tb_mem_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer just past the winner. Grant is purely combinational.
module tb_mem_rr_arbiter
  import tb_mem_pkg::*;
#(
  parameter int unsigned NumPorts = 2,
  parameter int unsigned PortW    = idx_width(NumPorts)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumPorts-1:0] req_i,
  output logic [NumPorts-1:0] gnt_o,
  output logic [PortW-1:0]    gnt_idx_o,
  output logic                gnt_valid_o
);

  logic [PortW-1:0] ptr_q;
  logic [PortW-1:0] ptr_d;
  logic [PortW-1:0] cand;
  logic [PortW-1:0] win;
  logic             found;

  // Scan requesters starting at the pointer and pick the first one found.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NumPorts; k++) begin
      cand = PortW'((32'(ptr_q) + k) % NumPorts);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    gnt_o = '0;
    if (found) gnt_o[win] = 1'b1;
    gnt_idx_o   = win;
    gnt_valid_o = found;
    ptr_d       = found ? PortW'((32'(win) + 1) % NumPorts) : ptr_q;
  end

  // Pointer register; holds when nothing is granted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/tb_multiport_mem.sv
// Multi-port simulation memory: NumPorts req/gnt/rvalid channels share one
// word-addressed array through a round-robin arbiter, with a fixed response
// latency of ReadLatency cycles after the grant.
// Optional feature macro: TB_MEM_EXIT_EN enables tohost exit-code detection.
module tb_multiport_mem
  import tb_mem_pkg::*;
#(
  parameter int unsigned NumPorts    = 2,
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned AddrWidth   = 64,
  parameter int unsigned NumWords    = 2**20,
  parameter int unsigned ReadLatency = 1,
  parameter logic [63:0] ToHostAddr  = 64'h8000_1000
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NumPorts-1:0]                   req_i,
  output logic [NumPorts-1:0]                   gnt_o,
  input  logic [NumPorts-1:0]                   we_i,
  input  logic [NumPorts-1:0][AddrWidth-1:0]    addr_i,
  input  logic [NumPorts-1:0][DataWidth/8-1:0]  be_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]    wdata_i,
  output logic [NumPorts-1:0]                   rvalid_o,
  output logic [NumPorts-1:0][DataWidth-1:0]    rdata_o,
  output logic [31:0]                           exit_o,
  output logic                                  exit_valid_o
);

  localparam int unsigned BeW   = DataWidth / 8;
  localparam int unsigned OffW  = $clog2(BeW);
  localparam int unsigned IdxW  = $clog2(NumWords);
  localparam int unsigned PortW = idx_width(NumPorts);

  // Response entry travelling from grant to the output registers.
  typedef struct packed {
    resp_ctrl_t           ctrl;
    logic [DataWidth-1:0] data;
  } resp_t;

  // ---------------------------------------------------------------------------
  // Arbitration and request selection
  // ---------------------------------------------------------------------------
  logic [PortW-1:0]     gnt_idx;
  logic                 gnt_valid;
  logic                 sel_we;
  logic [AddrWidth-1:0] sel_addr;
  logic [BeW-1:0]       sel_be;
  logic [DataWidth-1:0] sel_wdata;
  logic [IdxW-1:0]      word_idx;

  tb_mem_rr_arbiter #(
    .NumPorts (NumPorts),
    .PortW    (PortW)
  ) u_arb (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  // Route the winning port's request fields to the array.
  always_comb begin
    sel_we    = we_i[gnt_idx];
    sel_addr  = addr_i[gnt_idx];
    sel_be    = be_i[gnt_idx];
    sel_wdata = wdata_i[gnt_idx];
  end

  // Sub-word offset and bits above the array depth are dropped, so addresses alias.
  assign word_idx = sel_addr[IdxW+OffW-1:OffW];

  logic unused_addr;
  assign unused_addr = ^sel_addr;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [DataWidth-1:0] mem_q [NumWords];

  // Byte-masked write on the grant edge; the array itself is never cleared.
  always_ff @(posedge clk_i) begin
    // NOTE: the array has no reset -- clearing a memory-sized array would prevent RAM inference and reset does not promise contents.
    if (gnt_valid && sel_we) begin
      for (int unsigned b = 0; b < BeW; b++) begin
        if (sel_be[b]) mem_q[word_idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response pipeline
  // ---------------------------------------------------------------------------
  resp_t head_d;
  resp_t tail_d;

  // Entry formed in the grant cycle; reads see the word before a same-edge write.
  always_comb begin
    head_d.ctrl.valid = gnt_valid;
    head_d.ctrl.port  = port_id_t'(gnt_idx);
    head_d.data       = sel_we ? '0 : mem_q[word_idx];
  end

  if (ReadLatency == 1) begin : g_no_pipe
    assign tail_d = head_d;
  end else begin : g_pipe
    resp_t pipe_q [ReadLatency-1];

    // Delay line between the grant and the output registers; flushed by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int unsigned i = 0; i < ReadLatency - 1; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= head_d;
        for (int unsigned i = 1; i < ReadLatency - 1; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign tail_d = pipe_q[ReadLatency-2];
  end

  logic [NumPorts-1:0]                rvalid_d;
  logic [NumPorts-1:0]                rvalid_q;
  logic [NumPorts-1:0][DataWidth-1:0] rdata_q;

  // Decode which port the leaving entry belongs to.
  always_comb begin
    rvalid_d = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      rvalid_d[i] = tail_d.ctrl.valid && (tail_d.ctrl.port == port_id_t'(i));
    end
  end

  // Output registers: rvalid pulses for one cycle, rdata holds between responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      for (int unsigned i = 0; i < NumPorts; i++) begin
        if (rvalid_d[i]) rdata_q[i] <= tail_d.data;
      end
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;

  // ---------------------------------------------------------------------------
  // Exit detection
  // ---------------------------------------------------------------------------
`ifdef TB_MEM_EXIT_EN
  localparam logic [IdxW-1:0] ToHostIdx = ToHostAddr[IdxW+OffW-1:OffW];

  logic [31:0] exit_q;
  logic        exit_valid_q;
  logic [63:0] wdata_ext;
  logic        exit_hit;

  assign wdata_ext = 64'(sel_wdata);
  assign exit_hit  = gnt_valid && sel_we && (word_idx == ToHostIdx) &&
                     sel_be[0] && sel_wdata[0] && !exit_valid_q;

  // First qualifying tohost write latches the code; later ones are ignored.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exit_q       <= '0;
      exit_valid_q <= 1'b0;
    end else if (exit_hit) begin
      exit_q       <= wdata_ext[32:1];
      exit_valid_q <= 1'b1;
    end
  end

  assign exit_o       = exit_q;
  assign exit_valid_o = exit_valid_q;
`else
  logic unused_tohost;
  assign unused_tohost = ^ToHostAddr;

  assign exit_o       = '0;
  assign exit_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_tb_multiport_mem.sv
// Self-checking bench for tb_multiport_mem (2 ports, 64-bit words, 1024 words,
// ReadLatency 4). A negedge monitor models arbitration and storage, pushes
// expected responses into a queue on each grant and pops them when due.
module tb_tb_multiport_mem;

  localparam int          NP     = 2;
  localparam int          DW     = 64;
  localparam int          AW     = 64;
  localparam int          NW     = 1024;
  localparam int          LAT    = 4;
  localparam logic [63:0] TOHOST = 64'h8000_1000;

  logic                   clk;
  logic                   rst_n;
  logic [NP-1:0]          req;
  logic [NP-1:0]          gnt;
  logic [NP-1:0]          we;
  logic [NP-1:0][AW-1:0]  addr;
  logic [NP-1:0][DW/8-1:0] be;
  logic [NP-1:0][DW-1:0]  wdata;
  logic [NP-1:0]          rvalid;
  logic [NP-1:0][DW-1:0]  rdata;
  logic [31:0]            exit_code;
  logic                   exit_valid;

  tb_multiport_mem #(
    .NumPorts    (NP),
    .DataWidth   (DW),
    .AddrWidth   (AW),
    .NumWords    (NW),
    .ReadLatency (LAT),
    .ToHostAddr  (TOHOST)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_i        (req),
    .gnt_o        (gnt),
    .we_i         (we),
    .addr_i       (addr),
    .be_i         (be),
    .wdata_i      (wdata),
    .rvalid_o     (rvalid),
    .rdata_o      (rdata),
    .exit_o       (exit_code),
    .exit_valid_o (exit_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard and reference model
  typedef struct {
    int          due;
    int          port;
    logic [63:0] data;
    bit          known;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] mem_m [int];
  int          rr_ptr = 0;
  int          cyc = 0;
  logic [63:0] last_rdata [NP];
  bit          last_known [NP];

  always @(negedge clk) begin
    int          gi;
    int          p;
    int          idx;
    bit          ev;
    bit          ex;
    logic [NP-1:0] eg;
    logic [63:0] w;
    exp_t        e;
    if (!rst_n) begin
      exp_q.delete();
      rr_ptr = 0;
      for (int i = 0; i < NP; i++) begin
        last_rdata[i] = '0;
        last_known[i] = 1'b1;
      end
      n_cmp++;
      if (rvalid !== '0) begin
        n_err++;
        $display("FAIL mon_reset_rvalid: got %b want 0", rvalid);
      end
    end else begin
      gi = -1;
      for (int k = 0; k < NP; k++) begin
        p = (rr_ptr + k) % NP;
        if (gi < 0 && req[p]) gi = p;
      end
      eg = '0;
      if (gi >= 0) eg[gi] = 1'b1;
      n_cmp++;
      if (gnt !== eg) begin
        n_err++;
        $display("FAIL mon_gnt cyc %0d: got %b want %b", cyc, gnt, eg);
      end
      if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        n_cmp++;
        n_err++;
        $display("FAIL mon_missed_resp port %0d due %0d", exp_q[0].port, exp_q[0].due);
        void'(exp_q.pop_front());
      end
      for (int i = 0; i < NP; i++) begin
        ev = exp_q.size() > 0 && exp_q[0].due == cyc && exp_q[0].port == i;
        n_cmp++;
        if (rvalid[i] !== ev) begin
          n_err++;
          $display("FAIL mon_rvalid port %0d cyc %0d: got %b want %b", i, cyc, rvalid[i], ev);
        end
        if (ev) begin
          e = exp_q.pop_front();
          if (e.known) begin
            n_cmp++;
            if (rdata[i] !== e.data) begin
              n_err++;
              $display("FAIL mon_rdata port %0d: got %h want %h", i, rdata[i], e.data);
            end
          end
          last_rdata[i] = e.data;
          last_known[i] = e.known;
        end else if (last_known[i]) begin
          n_cmp++;
          if (rdata[i] !== last_rdata[i]) begin
            n_err++;
            $display("FAIL mon_rdata_hold port %0d: got %h want %h", i, rdata[i], last_rdata[i]);
          end
        end
      end
      if (gi >= 0) begin
        idx = int'((addr[gi] >> 3) % NW);
        ex  = mem_m.exists(idx);
        e.due   = cyc + LAT;
        e.port  = gi;
        e.known = we[gi] || ex;
        e.data  = we[gi] ? 64'h0 : (ex ? mem_m[idx] : 64'h0);
        exp_q.push_back(e);
        if (we[gi]) begin
          w = ex ? mem_m[idx] : 64'h0;
          for (int b = 0; b < 8; b++) if (be[gi][b]) w[b*8 +: 8] = wdata[gi][b*8 +: 8];
          if (ex || be[gi] == 8'hFF) mem_m[idx] = w;
        end
        rr_ptr = (gi + 1) % NP;
      end
    end
    cyc++;
  end

  // Drive one request on a port and hold it until granted (bounded).
  task automatic issue(input int port, input logic w, input logic [63:0] a,
                       input logic [7:0] b, input logic [63:0] d);
    bit ok;
    ok          = 1'b0;
    req[port]   = 1'b1;
    we[port]    = w;
    addr[port]  = a;
    be[port]    = b;
    wdata[port] = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt[port]) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    req[port] = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL issue_timeout port %0d addr %h: got no grant want grant", port, a);
    end
  endtask

  // Wait (bounded) for the next response on a port; waited = -1 on timeout.
  task automatic wait_rvalid(input int port, output int waited, output logic [63:0] d);
    waited = -1;
    d      = '0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (rvalid[port]) begin
        waited = i;
        d      = rdata[port];
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL idle_timeout: got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rvalid !== '0 || rdata !== '0 || gnt !== '0) begin
        n_err++;
        $display("FAIL reset_outputs: got rvalid %b gnt %b rdata %h want all 0", rvalid, gnt, rdata);
      end
      n_cmp++;
      if (exit_code !== 32'h0 || exit_valid !== 1'b0) begin
        n_err++;
        $display("FAIL reset_exit: got %h/%b want 0/0", exit_code, exit_valid);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int          lat;
    logic [63:0] d;
    issue(0, 1'b1, 64'h40, 8'hFF, 64'h1122_3344_5566_7788);
    wait_rvalid(0, lat, d);
    n_cmp++;
    if (lat != LAT || d !== 64'h0) begin
      n_err++;
      $display("FAIL basic_write_resp: got lat %0d data %h want lat %0d data 0", lat, d, LAT);
    end
    issue(0, 1'b0, 64'h40, 8'h00, 64'h0);
    wait_rvalid(0, lat, d);
    n_cmp++;
    if (lat != LAT || d !== 64'h1122_3344_5566_7788) begin
      n_err++;
      $display("FAIL basic_read: got lat %0d data %h want lat %0d data 1122334455667788", lat, d, LAT);
    end
  endtask

  task automatic test_partial();
    int          lat;
    logic [63:0] d;
    issue(0, 1'b1, 64'h40, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB);
    wait_rvalid(0, lat, d);
    issue(0, 1'b0, 64'h44, 8'h00, 64'h0);
    wait_rvalid(0, lat, d);
    n_cmp++;
    if (d !== 64'h1122_3344_BBBB_BBBB) begin
      n_err++;
      $display("FAIL partial_write: got %h want 11223344bbbbbbbb", d);
    end
  endtask

  task automatic test_aliasing();
    int          lat;
    logic [63:0] d;
    issue(1, 1'b1, 64'(NW * 8 + 'h40), 8'hFF, 64'h5555_6666_7777_8888);
    wait_rvalid(1, lat, d);
    issue(1, 1'b0, 64'h40, 8'h00, 64'h0);
    wait_rvalid(1, lat, d);
    n_cmp++;
    if (d !== 64'h5555_6666_7777_8888) begin
      n_err++;
      $display("FAIL alias_read: got %h want 5555666677778888", d);
    end
  endtask

  task automatic test_alternate();
    int          lat;
    logic [63:0] d;
    logic [NP-1:0] want;
    int          seen [NP];
    issue(1, 1'b1, 64'h80, 8'hFF, 64'hCAFE_F00D_DEAD_BEEF);
    wait_rvalid(1, lat, d);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    req   = 2'b11;
    we    = 2'b00;
    addr[0] = 64'h40;
    addr[1] = 64'h80;
    seen[0] = 0;
    seen[1] = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i < 8) begin
        want = (i % 2 == 0) ? 2'b01 : 2'b10;
        n_cmp++;
        if (gnt !== want) begin
          n_err++;
          $display("FAIL alternate_gnt step %0d: got %b want %b", i, gnt, want);
        end
      end
      for (int p = 0; p < NP; p++) if (rvalid[p]) seen[p]++;
      @(posedge clk); #1;
      if (i == 7) req = 2'b00;
    end
    n_cmp++;
    if (seen[0] != 4 || seen[1] != 4) begin
      n_err++;
      $display("FAIL alternate_resp_count: got %0d/%0d want 4/4", seen[0], seen[1]);
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int          lat;
    logic [63:0] d;
    logic [63:0] tbl [6];
    bit          want_g;
    bit          want_v;
    for (int k = 0; k < 6; k++) begin
      tbl[k] = 64'h0BAD_F00D_0000_0000 | 64'(k * 17 + 3);
      issue(0, 1'b1, 64'h100 + 64'(8 * k), 8'hFF, tbl[k]);
      wait_rvalid(0, lat, d);
    end
    req[0]  = 1'b1;
    we[0]   = 1'b0;
    addr[0] = 64'h100;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      want_g = (k < 6);
      want_v = (k >= LAT && k < LAT + 6);
      n_cmp++;
      if (gnt[0] !== want_g) begin
        n_err++;
        $display("FAIL b2b_gnt step %0d: got %b want %b", k, gnt[0], want_g);
      end
      n_cmp++;
      if (rvalid[0] !== want_v) begin
        n_err++;
        $display("FAIL b2b_rvalid step %0d: got %b want %b", k, rvalid[0], want_v);
      end
      if (want_v) begin
        n_cmp++;
        if (rdata[0] !== tbl[k-LAT]) begin
          n_err++;
          $display("FAIL b2b_rdata step %0d: got %h want %h", k, rdata[0], tbl[k-LAT]);
        end
      end
      @(posedge clk); #1;
      if (k < 5)  addr[0] = 64'h100 + 64'(8 * (k + 1));
      if (k == 5) req[0]  = 1'b0;
    end
    wait_idle();
  endtask

  task automatic test_exit();
    int          lat;
    logic [63:0] d;
    issue(0, 1'b1, TOHOST, 8'hFF, 64'h7);
    wait_rvalid(0, lat, d);
`ifdef TB_MEM_EXIT_EN
    n_cmp++;
    if (exit_valid !== 1'b1 || exit_code !== 32'd3) begin
      n_err++;
      $display("FAIL exit_first: got %b/%0d want 1/3", exit_valid, exit_code);
    end
    issue(0, 1'b1, TOHOST, 8'hFF, 64'h9);
    wait_rvalid(0, lat, d);
    n_cmp++;
    if (exit_valid !== 1'b1 || exit_code !== 32'd3) begin
      n_err++;
      $display("FAIL exit_sticky: got %b/%0d want 1/3", exit_valid, exit_code);
    end
`else
    n_cmp++;
    if (exit_valid !== 1'b0 || exit_code !== 32'd0) begin
      n_err++;
      $display("FAIL exit_disabled: got %b/%0d want 0/0", exit_valid, exit_code);
    end
`endif
    issue(0, 1'b0, TOHOST, 8'h00, 64'h0);
    wait_rvalid(0, lat, d);
    n_cmp++;
    if (d !== 64'h7) begin
      n_err++;
      $display("FAIL tohost_stored: got %h want 7", d);
    end
  endtask

  task automatic test_reset_midflight();
    issue(0, 1'b0, 64'h40, 8'h00, 64'h0);
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rvalid !== '0) begin
        n_err++;
        $display("FAIL midreset_rvalid_in_reset: got %b want 0", rvalid);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rvalid !== '0) begin
        n_err++;
        $display("FAIL midreset_dropped step %0d: got %b want 0", i, rvalid);
      end
    end
    n_cmp++;
    if (exit_valid !== 1'b0 || exit_code !== 32'd0) begin
      n_err++;
      $display("FAIL midreset_exit_cleared: got %b/%0d want 0/0", exit_valid, exit_code);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    we    = '0;
    addr  = '0;
    be    = '0;
    wdata = '0;
    test_reset();
    test_basic();
    test_partial();
    test_aliasing();
    test_alternate();
    test_back_to_back();
    test_exit();
    test_reset_midflight();
    wait_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
